mem_stage_sram: RTL

Memory stage of the ARM pipeline with an external 16-bit asynchronous SRAM. It sits directly downstream of the execute stage and consumes its ALU result, forwarded Rm value and control bits. It performs each 32-bit LDR/STR as two halfword SRAM accesses through a multi-cycle FSM. It deasserts `ready_out` so the top level freezes every pipeline register until the access completes.

---
 rtl/mem_stage_sram.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mem_stage_sram.sv
// Memory stage: 32-bit LDR/STR as two halfword accesses to a 16-bit async SRAM.
// Stalls the pipeline via ready_out while the access FSM is busy.
module mem_stage_sram #(
  parameter int ADDR_BASE    = 1024,
  parameter int SRAM_ADDR_W  = 18,
  parameter int PHASE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_en_in,
  input  logic                   mem_r_en_in,
  input  logic                   mem_w_en_in,
  input  logic [3:0]             wb_reg_dest_in,
  input  logic [31:0]            alu_result_in,
  input  logic [31:0]            val_rm_in,
  output logic                   wb_en_out,
  output logic                   mem_r_en_out,
  output logic [3:0]             wb_reg_dest_out,
  output logic [31:0]            alu_result_out,
  output logic [31:0]            mem_read_value_out,
  output logic                   ready_out,
  output logic [SRAM_ADDR_W-1:0] sram_addr_out,
  inout  wire logic [15:0]       sram_dq_inout,
  output logic                   sram_we_n_out
);

  localparam int CW = $clog2(PHASE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(PHASE_CYCLES - 1);
  localparam logic [CW-1:0] PRE  = CW'(PHASE_CYCLES - 2);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [SRAM_ADDR_W-2:0] w;
  logic [31:0]            wdata;
  logic                   is_wr;
  logic [31:0]            rdata;
  logic [SRAM_ADDR_W-1:0] addr_q;
  logic                   we_n_q;
  logic                   drv;
  logic [15:0]            dout;

  logic                   req;
  logic [31:0]            off;
  logic [SRAM_ADDR_W-2:0] w_new;
  logic                   unused_off;

  assign req        = mem_r_en_in | mem_w_en_in;
  assign off        = alu_result_in - 32'(ADDR_BASE);
  assign w_new      = off[SRAM_ADDR_W:2];
  assign unused_off = ^{off[31:SRAM_ADDR_W+1], off[1:0]};

  assign wb_en_out       = wb_en_in;
  assign mem_r_en_out    = mem_r_en_in;
  assign wb_reg_dest_out = wb_reg_dest_in;
  assign alu_result_out  = alu_result_in;

  assign mem_read_value_out = rdata;
  assign ready_out          = ~req | (state == DONE);
  assign sram_addr_out      = addr_q;
  assign sram_we_n_out      = we_n_q;
  assign sram_dq_inout      = drv ? dout : 16'bz;

  // Access FSM; SRAM pins are registered one cycle ahead of each phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      w      <= '0;
      wdata  <= '0;
      is_wr  <= 1'b0;
      rdata  <= '0;
      addr_q <= '0;
      we_n_q <= 1'b1;
      drv    <= 1'b0;
      dout   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            state  <= LOW;
            cnt    <= '0;
            w      <= w_new;
            wdata  <= val_rm_in;
            is_wr  <= mem_w_en_in;
            addr_q <= {w_new, 1'b0};
            we_n_q <= ~mem_w_en_in;
            drv    <= mem_w_en_in;
            dout   <= val_rm_in[15:0];
          end
        end
        LOW: begin
          if (cnt == LAST) begin
            state  <= HIGH;
            cnt    <= '0;
            addr_q <= {w, 1'b1};
            we_n_q <= ~is_wr;
            dout   <= wdata[31:16];
            if (!is_wr) rdata[15:0] <= sram_dq_inout;
          end else begin
            cnt <= cnt + CW'(1);
            if (cnt == PRE) we_n_q <= 1'b1;
          end
        end
        HIGH: begin
          if (cnt == LAST) begin
            state  <= DONE;
            cnt    <= '0;
            we_n_q <= 1'b1;
            drv    <= 1'b0;
            if (!is_wr) rdata[31:16] <= sram_dq_inout;
          end else begin
            cnt <= cnt + CW'(1);
            if (cnt == PRE) we_n_q <= 1'b1;
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end

endmodule
